// File: rtl/cc_obstacle_gen.sv
// cc_obstacle_gen: periodic pseudo-random obstacle row generator for the car game
// Ports:
//   CC_OBSTACLE_GEN_CLOCK_50      system clock, rising edge
//   CC_OBSTACLE_GEN_RESET_InLow   asynchronous active-low reset
//   CC_OBSTACLE_GEN_enable_In     game running; low parks the block in IDLE
//   CC_OBSTACLE_GEN_clear_In      synchronous restart of the row sequence
//   CC_OBSTACLE_GEN_ack_In        downstream has taken the current row
//   CC_OBSTACLE_GEN_row_OutBus    obstacle row, 1 = obstacle
//   CC_OBSTACLE_GEN_valid_Out     row is new and not yet acknowledged
//   CC_OBSTACLE_GEN_count_OutBus  rows generated since reset/clear, saturating
// Build option: define OBSTACLE_GEN_DENSITY_EN for sparse (~25%) rows.
module cc_obstacle_gen #(
    parameter int         OBS_DATAWIDTH = 8,
    parameter int         OBS_PERIOD    = 50000000,
    parameter logic [7:0] OBS_SEED      = 8'hA5
) (
    input  logic                     CC_OBSTACLE_GEN_CLOCK_50,
    input  logic                     CC_OBSTACLE_GEN_RESET_InLow,
    input  logic                     CC_OBSTACLE_GEN_enable_In,
    input  logic                     CC_OBSTACLE_GEN_clear_In,
    input  logic                     CC_OBSTACLE_GEN_ack_In,
    output logic [OBS_DATAWIDTH-1:0] CC_OBSTACLE_GEN_row_OutBus,
    output logic                     CC_OBSTACLE_GEN_valid_Out,
    output logic [7:0]               CC_OBSTACLE_GEN_count_OutBus
);
    typedef enum logic [1:0] {IDLE, COUNT, PRESENT} state_t;
    // an all-zero seed would lock the LFSR, so it is replaced by 1
    localparam logic [OBS_DATAWIDTH-1:0] SEED = (OBS_SEED == 8'h00) ? 8'h01 : OBS_SEED;
    localparam logic [25:0] LAST = 26'(OBS_PERIOD - 1);
    state_t                   state_q, state_d;
    logic [25:0]              presc_q, presc_d;
    logic [OBS_DATAWIDTH-1:0] lfsr_q, lfsr_d, lfsr_step, shaped_raw, shaped;
    logic [OBS_DATAWIDTH-1:0] row_q, row_d;
    logic                     valid_q, valid_d;
    logic [7:0]               count_q, count_d;
    always_comb begin
        lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`ifdef OBSTACLE_GEN_DENSITY_EN
        shaped_raw = lfsr_step & {lfsr_step[3:0], lfsr_step[7:4]};
`else
        shaped_raw = lfsr_step;
`endif
        // a full row would leave the car nowhere to go: open lane 0
        shaped = (shaped_raw == '1) ? {shaped_raw[7:1], 1'b0} : shaped_raw;
    end
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        lfsr_d  = lfsr_q;
        row_d   = row_q;
        valid_d = valid_q;
        count_d = count_q;
        if (CC_OBSTACLE_GEN_clear_In) begin
            presc_d = '0;
            lfsr_d  = SEED;
            row_d   = '0;
            valid_d = 1'b0;
            count_d = '0;
            state_d = CC_OBSTACLE_GEN_enable_In ? COUNT : IDLE;
        end else if (!CC_OBSTACLE_GEN_enable_In) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = COUNT;
                    presc_d = '0;
                end
                COUNT: begin
                    if (presc_q == LAST) begin
                        lfsr_d  = lfsr_step;
                        row_d   = shaped;
                        valid_d = 1'b1;
                        count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                        presc_d = '0;
                        state_d = PRESENT;
                    end else begin
                        presc_d = presc_q + 26'd1;
                    end
                end
                PRESENT: begin
                    // prescaler is frozen here so a slow consumer never loses a row
                    if (CC_OBSTACLE_GEN_ack_In) begin
                        valid_d = 1'b0;
                        presc_d = '0;
                        state_d = COUNT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge CC_OBSTACLE_GEN_CLOCK_50 or negedge CC_OBSTACLE_GEN_RESET_InLow) begin
        if (!CC_OBSTACLE_GEN_RESET_InLow) begin
            state_q <= IDLE;
            presc_q <= '0;
            lfsr_q  <= SEED;
            row_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            lfsr_q  <= lfsr_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end
    assign CC_OBSTACLE_GEN_row_OutBus   = row_q;
    assign CC_OBSTACLE_GEN_valid_Out    = valid_q;
    assign CC_OBSTACLE_GEN_count_OutBus = count_q;
endmodule
